// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: privilege levels, interrupt codes, tvec modes
// and the mstatus bit positions owned by the trap controller.
package riscv_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [1:0] {
    TVEC_DIRECT   = 2'd0,
    TVEC_VECTORED = 2'd1
  } tvec_mode_e;

  typedef enum logic [1:0] {
    XKIND_TRAP,
    XKIND_MRET,
    XKIND_SRET
  } xkind_e;

  localparam int unsigned IRQ_MEI = 11;
  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_SEI = 9;
  localparam int unsigned IRQ_SSI = 1;
  localparam int unsigned IRQ_STI = 5;

  localparam int unsigned IRQ_W = 12;
  // Only S-level interrupts may be delegated.
  localparam logic [IRQ_W-1:0] IRQ_S_MASK = 12'h222;

  localparam int unsigned MS_SIE    = 1;
  localparam int unsigned MS_MIE    = 3;
  localparam int unsigned MS_SPIE   = 5;
  localparam int unsigned MS_MPIE   = 7;
  localparam int unsigned MS_SPP    = 8;
  localparam int unsigned MS_MPP_LO = 11;

  // Fixed priority MEI > MSI > MTI > SEI > SSI > STI; caller qualifies with |en.
  function automatic logic [3:0] irq_pick(input logic [IRQ_W-1:0] en);
    if (en[IRQ_MEI])      return 4'(IRQ_MEI);
    else if (en[IRQ_MSI]) return 4'(IRQ_MSI);
    else if (en[IRQ_MTI]) return 4'(IRQ_MTI);
    else if (en[IRQ_SEI]) return 4'(IRQ_SEI);
    else if (en[IRQ_SSI]) return 4'(IRQ_SSI);
    else                  return 4'(IRQ_STI);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // NOTE: non-blocking assignment makes every flop sample the previous stage's old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= '0;
    else         r_sync <= {r_sync[STAGES-2:0], d_i};
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Commit-stage trap/interrupt controller: arbitrates traps and xret, sequences
// flush and redirect, and owns privilege level plus the mstatus interrupt stack.
module trap_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_cause_i,
  input  logic [XLEN-1:0] ex_tval_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            head_valid_i,
  input  logic [XLEN-1:0] head_pc_i,
  input  logic            mret_i,
  input  logic            sret_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            meip_i,
  input  logic            ssip_i,
  input  logic            stip_i,
  input  logic            seip_i,
  input  logic [XLEN-1:0] mie_csr_i,
  input  logic [XLEN-1:0] mideleg_i,
  input  logic [XLEN-1:0] medeleg_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] stvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] sepc_i,
  input  logic            status_we_i,
  input  logic [XLEN-1:0] status_wdata_i,
  output logic            flush_o,
  input  logic            flush_done_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_we_o,
  output logic            trap_to_s_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic [XLEN-1:0] trap_epc_o,
  output logic [XLEN-1:0] trap_tval_o,
  output priv_lvl_t       priv_o,
  output logic [XLEN-1:0] status_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_COMMIT} trap_state_e;

  trap_state_e      r_state, w_state_n;
  xkind_e           r_kind, w_kind;
  logic             r_to_s, w_to_s, w_take;
  logic [XLEN-1:0]  r_cause, r_epc, r_tval, r_target;
  logic [XLEN-1:0]  w_cause, w_epc, w_tval, w_target, w_tvec, w_irq_cause, w_status;
  priv_lvl_t        r_priv, r_mpp;
  logic             r_mie, r_mpie, r_sie, r_spie, r_spp;
  logic             w_meip_s, w_seip_s, w_irq, w_m_en, w_s_en, w_unused;
  logic [IRQ_W-1:0] w_pend, w_deleg, w_en;
  logic [3:0]       w_code;
  logic [63:0]      w_medeleg;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_meip (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(meip_i), .q_o(w_meip_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_seip (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(seip_i), .q_o(w_seip_s));

  always_comb begin
    w_pend          = '0;
    w_pend[IRQ_MEI] = w_meip_s;
    w_pend[IRQ_MSI] = msip_i;
    w_pend[IRQ_MTI] = mtip_i;
    w_pend[IRQ_SEI] = w_seip_s;
    w_pend[IRQ_SSI] = ssip_i;
    w_pend[IRQ_STI] = stip_i;
    w_pend          = w_pend & mie_csr_i[IRQ_W-1:0];
  end

  assign w_deleg   = mideleg_i[IRQ_W-1:0] & IRQ_S_MASK;
  assign w_m_en    = (r_priv != PRIV_LVL_M) || r_mie;
  assign w_s_en    = (r_priv == PRIV_LVL_U) || ((r_priv == PRIV_LVL_S) && r_sie);
  assign w_en      = w_pend & ((~w_deleg & {IRQ_W{w_m_en}}) | (w_deleg & {IRQ_W{w_s_en}}));
  assign w_irq     = |w_en;
  assign w_code    = irq_pick(w_en);
  assign w_medeleg = 64'(medeleg_i);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_n   = r_state;
    w_take      = 1'b0;
    w_kind      = XKIND_TRAP;
    w_to_s      = 1'b0;
    w_cause     = '0;
    w_epc       = '0;
    w_tval      = '0;
    w_target    = '0;
    w_tvec      = '0;
    w_irq_cause = '0;
    w_irq_cause[XLEN-1] = 1'b1;
    w_irq_cause[3:0]    = w_code;
    unique case (r_state)
      ST_IDLE: begin
        if (head_valid_i) begin
          if (w_irq) begin
            w_take  = 1'b1;
            w_to_s  = w_deleg[w_code];
            w_cause = w_irq_cause;
            w_epc   = head_pc_i;
          end else if (ex_valid_i) begin
            w_take  = 1'b1;
            w_to_s  = (r_priv != PRIV_LVL_M) && w_medeleg[ex_cause_i[5:0]];
            w_cause = ex_cause_i;
            w_epc   = ex_pc_i;
            w_tval  = ex_tval_i;
          end else if (mret_i) begin
            w_take   = 1'b1;
            w_kind   = XKIND_MRET;
            w_target = mepc_i;
          end else if (sret_i) begin
            w_take   = 1'b1;
            w_kind   = XKIND_SRET;
            w_target = sepc_i;
          end
          if (w_take && (w_kind == XKIND_TRAP)) begin
            w_tvec   = w_to_s ? stvec_i : mtvec_i;
            w_target = {w_tvec[XLEN-1:2], 2'b00};
            if (w_irq && (w_tvec[1:0] == 2'(TVEC_VECTORED)))
              w_target = w_target + XLEN'({w_code, 2'b00});
          end
          if (w_take) w_state_n = ST_FLUSH;
        end
      end
      ST_FLUSH:  if (flush_done_i) w_state_n = ST_COMMIT;
      ST_COMMIT: w_state_n = ST_IDLE;
      default:   w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_n;
  end

  // Winner is frozen on leaving IDLE so later input changes cannot disturb the commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_kind   <= XKIND_TRAP;
      r_to_s   <= 1'b0;
      r_cause  <= '0;
      r_epc    <= '0;
      r_tval   <= '0;
      r_target <= '0;
    end else if (w_take) begin
      r_kind   <= w_kind;
      r_to_s   <= w_to_s;
      r_cause  <= w_cause;
      r_epc    <= w_epc;
      r_tval   <= w_tval;
      r_target <= w_target;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_priv <= PRIV_LVL_M;
      r_mpp  <= PRIV_LVL_M;
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
      r_sie  <= 1'b0;
      r_spie <= 1'b0;
      r_spp  <= 1'b0;
    end else if (r_state == ST_COMMIT) begin
      unique case (r_kind)
        XKIND_TRAP: begin
          if (r_to_s) begin
            r_spie <= r_sie;
            r_sie  <= 1'b0;
            r_spp  <= r_priv[0];
            r_priv <= PRIV_LVL_S;
          end else begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
            r_mpp  <= r_priv;
            r_priv <= PRIV_LVL_M;
          end
        end
        XKIND_MRET: begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
          r_priv <= r_mpp;
          r_mpp  <= PRIV_LVL_U;
        end
        XKIND_SRET: begin
          r_sie  <= r_spie;
          r_spie <= 1'b1;
          r_priv <= r_spp ? PRIV_LVL_S : PRIV_LVL_U;
          r_spp  <= 1'b0;
        end
        default: ;
      endcase
    end else if (status_we_i) begin
      r_sie  <= status_wdata_i[MS_SIE];
      r_mie  <= status_wdata_i[MS_MIE];
      r_spie <= status_wdata_i[MS_SPIE];
      r_mpie <= status_wdata_i[MS_MPIE];
      r_spp  <= status_wdata_i[MS_SPP];
      r_mpp  <= (status_wdata_i[MS_MPP_LO+:2] == 2'b10) ? PRIV_LVL_U
                                                        : priv_lvl_t'(status_wdata_i[MS_MPP_LO+:2]);
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[MS_SIE]       = r_sie;
    w_status[MS_MIE]       = r_mie;
    w_status[MS_SPIE]      = r_spie;
    w_status[MS_MPIE]      = r_mpie;
    w_status[MS_SPP]       = r_spp;
    w_status[MS_MPP_LO+:2] = r_mpp;
  end

  assign flush_o          = (r_state == ST_FLUSH);
  assign redirect_valid_o = (r_state == ST_COMMIT);
  assign trap_we_o        = (r_state == ST_COMMIT) && (r_kind == XKIND_TRAP);
  assign redirect_pc_o    = r_target;
  assign trap_to_s_o      = r_to_s;
  assign trap_cause_o     = r_cause;
  assign trap_epc_o       = r_epc;
  assign trap_tval_o      = r_tval;
  assign priv_o           = r_priv;
  assign status_o         = w_status;

  assign w_unused = ^{mie_csr_i[XLEN-1:IRQ_W], mideleg_i[XLEN-1:IRQ_W], status_wdata_i[XLEN-1:13],
                      status_wdata_i[10:9], status_wdata_i[6], status_wdata_i[4], status_wdata_i[2],
                      status_wdata_i[0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected redirects are queued as stimulus is
// driven and compared by a monitor when redirect_valid_o fires.
module tb_trap_ctrl;
  import riscv_pkg::*;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            ex_valid_i, head_valid_i, mret_i, sret_i;
  logic [XLEN-1:0] ex_cause_i, ex_tval_i, ex_pc_i, head_pc_i;
  logic            msip_i, mtip_i, meip_i, ssip_i, stip_i, seip_i;
  logic [XLEN-1:0] mie_csr_i, mideleg_i, medeleg_i, mtvec_i, stvec_i, mepc_i, sepc_i;
  logic            status_we_i;
  logic [XLEN-1:0] status_wdata_i;
  logic            flush_o, flush_done_i, redirect_valid_o, trap_we_o, trap_to_s_o;
  logic [XLEN-1:0] redirect_pc_o, trap_cause_o, trap_epc_o, trap_tval_o, status_o;
  priv_lvl_t       priv_o;

  trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_cause_i(ex_cause_i), .ex_tval_i(ex_tval_i), .ex_pc_i(ex_pc_i),
    .head_valid_i(head_valid_i), .head_pc_i(head_pc_i), .mret_i(mret_i), .sret_i(sret_i),
    .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i), .ssip_i(ssip_i), .stip_i(stip_i), .seip_i(seip_i),
    .mie_csr_i(mie_csr_i), .mideleg_i(mideleg_i), .medeleg_i(medeleg_i),
    .mtvec_i(mtvec_i), .stvec_i(stvec_i), .mepc_i(mepc_i), .sepc_i(sepc_i),
    .status_we_i(status_we_i), .status_wdata_i(status_wdata_i),
    .flush_o(flush_o), .flush_done_i(flush_done_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .trap_we_o(trap_we_o), .trap_to_s_o(trap_to_s_o),
    .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o), .trap_tval_o(trap_tval_o),
    .priv_o(priv_o), .status_o(status_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            we;
    logic            to_s;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_trap(input logic [XLEN-1:0] pc, input logic to_s, input logic [XLEN-1:0] cause,
                           input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval);
    exp_t e;
    e.pc = pc; e.we = 1'b1; e.to_s = to_s; e.cause = cause; e.epc = epc; e.tval = tval;
    sb_q.push_back(e);
  endtask

  task automatic push_xret(input logic [XLEN-1:0] pc);
    exp_t e;
    e.pc = pc; e.we = 1'b0; e.to_s = 1'b0; e.cause = '0; e.epc = '0; e.tval = '0;
    sb_q.push_back(e);
  endtask

  // Called at the negedge where the winning stimulus has just been driven.
  task automatic run_txn(input int n_flush, input logic wr_in_commit, input logic [XLEN-1:0] wdata);
    flush_done_i = 1'b0;
    for (int k = 1; k <= n_flush; k++) begin
      @(negedge clk_i);
      check("flush_high", flush_o, 1);
      check("no_early_redirect", redirect_valid_o, 0);
      if (k == n_flush) flush_done_i = 1'b1;
    end
    @(negedge clk_i);
    check("redirect_pulse", redirect_valid_o, 1);
    head_valid_i = 1'b0;
    ex_valid_i   = 1'b0;
    mret_i       = 1'b0;
    sret_i       = 1'b0;
    if (wr_in_commit) begin
      status_we_i    = 1'b1;
      status_wdata_i = wdata;
    end
    @(negedge clk_i);
    status_we_i = 1'b0;
    check("redirect_single", redirect_valid_o, 0);
    check("flush_dropped", flush_o, 0);
  endtask

  task automatic write_status(input logic [XLEN-1:0] wdata);
    status_we_i    = 1'b1;
    status_wdata_i = wdata;
    @(negedge clk_i);
    status_we_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && redirect_valid_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_redirect", redirect_valid_o, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("redirect_pc", redirect_pc_o, mon_e.pc);
        check("trap_we", trap_we_o, mon_e.we);
        if (mon_e.we) begin
          check("trap_to_s", trap_to_s_o, mon_e.to_s);
          check("trap_cause", trap_cause_o, mon_e.cause);
          check("trap_epc", trap_epc_o, mon_e.epc);
          check("trap_tval", trap_tval_o, mon_e.tval);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    {ex_valid_i, head_valid_i, mret_i, sret_i, status_we_i} = '0;
    {msip_i, mtip_i, meip_i, ssip_i, stip_i, seip_i} = '0;
    ex_cause_i = '0; ex_tval_i = '0; ex_pc_i = '0; head_pc_i = '0;
    mie_csr_i = '0; mideleg_i = '0; medeleg_i = '0;
    mtvec_i = 32'h200; stvec_i = 32'h8000_0000; mepc_i = '0; sepc_i = '0;
    status_wdata_i = '0;
    flush_done_i = 1'b1;

    repeat (2) @(negedge clk_i);
    check("rst_priv", priv_o, PRIV_LVL_M);
    check("rst_status", status_o, 32'h1800);
    check("rst_flush", flush_o, 0);
    check("rst_redirect", redirect_valid_o, 0);
    check("rst_trap_we", trap_we_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // mret from M into U with mpie set
    write_status(32'h0000_0080);
    check("wr_status", status_o, 32'h80);
    mepc_i = 32'h2000; mret_i = 1'b1; head_valid_i = 1'b1;
    push_xret(32'h2000);
    run_txn(1, 1'b0, '0);
    check("mret_priv", priv_o, PRIV_LVL_U);
    check("mret_status", status_o, 32'h88);

    // Illegal instruction at U delegated to S
    medeleg_i = 32'h4; ex_cause_i = 32'd2; ex_tval_i = 32'hdead; ex_pc_i = 32'h400;
    ex_valid_i = 1'b1; head_valid_i = 1'b1;
    push_trap(32'h8000_0000, 1'b1, 32'd2, 32'h400, 32'hdead);
    run_txn(1, 1'b0, '0);
    check("deleg_priv", priv_o, PRIV_LVL_S);
    check("deleg_status", status_o, 32'h88);

    // sret back to U (spp was 0)
    sepc_i = 32'h2100; sret_i = 1'b1; head_valid_i = 1'b1;
    push_xret(32'h2100);
    run_txn(1, 1'b0, '0);
    check("sret_priv", priv_o, PRIV_LVL_U);
    check("sret_status", status_o, 32'hA8);

    // MEI beats MTI and a pending exception
    mie_csr_i = 32'h880; meip_i = 1'b1; mtip_i = 1'b1;
    ex_valid_i = 1'b1; ex_cause_i = 32'd2; ex_pc_i = 32'h700; head_pc_i = 32'h600;
    repeat (3) @(negedge clk_i);
    check("no_trap_without_head", flush_o, 0);
    head_valid_i = 1'b1;
    push_trap(32'h200, 1'b0, 32'h8000_000B, 32'h600, 32'h0);
    run_txn(1, 1'b0, '0);
    meip_i = 1'b0; mtip_i = 1'b0;
    check("mei_priv", priv_o, PRIV_LVL_M);
    check("mei_status", status_o, 32'hA0);

    // MTI masked at M while mstatus.mie=0
    mie_csr_i = 32'h80; mtip_i = 1'b1; head_valid_i = 1'b1; head_pc_i = 32'h3000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("mti_masked", flush_o, 0);
    end
    head_valid_i = 1'b0;
    write_status(32'h0000_1808);
    check("wr_mie", status_o, 32'h1808);
    mtvec_i = 32'h101; head_valid_i = 1'b1;
    push_trap(32'h11C, 1'b0, 32'h8000_0007, 32'h3000, 32'h0);
    run_txn(1, 1'b0, '0);
    mtip_i = 1'b0; mie_csr_i = '0;
    check("mti_status", status_o, 32'h1880);

    // ecall at M, slow flush, status write in COMMIT dropped
    ex_cause_i = 32'd11; ex_pc_i = 32'h500; ex_tval_i = 32'h0; ex_valid_i = 1'b1; head_valid_i = 1'b1;
    push_trap(32'h100, 1'b0, 32'd11, 32'h500, 32'h0);
    run_txn(5, 1'b1, 32'h0000_0088);
    check("commit_wr_dropped", status_o, 32'h1800);

    // mpp=2'b10 maps to U
    write_status(32'h0000_1000);
    check("mpp_illegal", status_o, 32'h0);
    check("mpp_priv_kept", priv_o, PRIV_LVL_M);

    mepc_i = 32'h2400; mret_i = 1'b1; head_valid_i = 1'b1;
    push_xret(32'h2400);
    run_txn(1, 1'b0, '0);
    check("mret2_priv", priv_o, PRIV_LVL_U);
    check("mret2_status", status_o, 32'h80);

    // Reset in the middle of FLUSH
    ex_cause_i = 32'd2; ex_pc_i = 32'h800; ex_valid_i = 1'b1; head_valid_i = 1'b1; flush_done_i = 1'b0;
    @(negedge clk_i);
    check("pre_rst_flush", flush_o, 1);
    @(negedge clk_i);
    check("pre_rst_flush_hold", flush_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_flush", flush_o, 0);
    check("rst_async_redirect", redirect_valid_o, 0);
    check("rst_async_priv", priv_o, PRIV_LVL_M);
    check("rst_async_status", status_o, 32'h1800);
    ex_valid_i = 1'b0; head_valid_i = 1'b0; flush_done_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("post_rst_no_redirect", redirect_valid_o, 0);
      check("post_rst_no_flush", flush_o, 0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
